// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel valid/ready stream mux with round-robin or fixed select
// and a registered output stage that reports the source channel.
module rr_stream_mux #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] ch_q, ch_d, ptr_q, ptr_d, gnt_idx;
    logic             valid_q, valid_d, gnt_found, load_en;
    int               c;
    // Round-robin scan runs from the farthest offset down so the nearest requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        c         = 0;
        if (mode) begin
            gnt_found = (int'(sel) < N_CH) && in_valid[sel];
            gnt_idx   = sel;
        end else begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                c = (int'(ptr_q) + k) % N_CH;
                if (in_valid[c]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = SEL_W'(c);
                end
            end
        end
    end
    assign load_en  = !valid_q || out_ready;
    assign in_ready = (load_en && gnt_found && !rst) ? N_CH'(1) << gnt_idx : '0;
    always_comb begin
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            valid_d = gnt_found;
            if (gnt_found) begin
                data_d = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
                ch_d   = gnt_idx;
                ptr_d  = (int'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end
    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed plus randomized checks of rr_stream_mux against
// a distance-based arbitration model.
module tb_rr_stream_mux;
    localparam int N = 4;
    localparam int W = 8;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic          mode;
    logic [SW-1:0] sel;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_ch;
    logic          out_valid;
    logic          out_ready;

    int checks = 0;
    int failures = 0;

    // model state
    bit       m_valid;
    bit [7:0] m_data;
    int       m_ch;
    int       m_ptr;

    rr_stream_mux #(.N_CH(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner is the requester at the smallest circular distance from the pointer.
    function automatic int model_grant(input logic [N-1:0] v, input bit md, input int s, input int p);
        int best = -1;
        int bestd = N;
        if (md) return (s < N && v[s]) ? s : -1;
        for (int ch = 0; ch < N; ch++)
            if (v[ch] && ((ch - p + N) % N) < bestd) begin
                bestd = (ch - p + N) % N;
                best = ch;
            end
        return best;
    endfunction

    task automatic step();
        bit load;
        int g;
        logic [N-1:0] exp_rdy;
        #1;
        load = !m_valid || out_ready;
        g = rst ? -1 : model_grant(in_valid, mode, int'(sel), m_ptr);
        exp_rdy = (load && g >= 0) ? N'(1) << g : '0;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (rst) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
        end else if (load) begin
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_data = in_data[g*W +: W];
                m_ch = g;
                m_ptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_ch", 32'(out_ch), 32'(m_ch));
    endtask

    initial begin
        rst = 1; mode = 0; sel = 0; out_ready = 1; in_valid = '1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
        // reset with all channels requesting
        step(); step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        rst = 0;
        // round-robin fairness
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_ch", 32'(out_ch), 32'(i % N));
            chk("rr_data", 32'(out_data), 32'(8'hA0 + 8'(i % N)));
        end
        step();
        chk("rr_ch2", 32'(out_ch), 32'd2);
        // sparse requests with wrap from pointer 3
        in_valid = 4'b1010;
        step(); chk("sparse_a", 32'(out_ch), 32'd3);
        step(); chk("sparse_b", 32'(out_ch), 32'd1);
        step(); chk("sparse_c", 32'(out_ch), 32'd3);
        // backpressure
        rst = 1; in_valid = '1; step();
        rst = 0; in_data[0 +: W] = 8'h11; step();
        chk("bp_first", 32'(out_data), 32'h11);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold", 32'(out_data), 32'h11);
            chk("bp_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1;
        step();
        chk("bp_next", 32'(out_ch), 32'd1);
        // fixed select
        mode = 1; sel = 2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fix_ch", 32'(out_ch), 32'd2);
        end
        in_valid[2] = 0;
        step();
        chk("fix_drop", 32'(out_valid), 32'd0);
        in_valid[2] = 1;
        step();
        chk("fix_again", 32'(out_ch), 32'd2);
        // switch back to round-robin resumes after ch2
        mode = 0; in_valid = '1;
        step(); chk("sw_a", 32'(out_ch), 32'd3);
        step(); chk("sw_b", 32'(out_ch), 32'd0);
        rst = 1;
        step();
        chk("rst_mid", 32'(out_valid), 32'd0);
        rst = 0;
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            in_valid = N'($urandom);
            for (int j = 0; j < N; j++) in_data[j*W +: W] = 8'($urandom);
            mode = ($urandom_range(0, 3) == 0);
            sel = SW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
